// File: rtl/multi_rate_circular_buffer_if.sv
// Handshake bundle for the multi-rate circular buffer: producer write port,
// consumer head window, pop request and status flags.
interface multi_rate_circular_buffer_if #(
  parameter int SIZE       = 16,
  parameter int WRITE_SIZE = 4,
  parameter int READ_SIZE  = 4,
  parameter int DATA_WIDTH = 8
);
  logic [WRITE_SIZE-1:0][DATA_WIDTH-1:0] in;
  logic                                  wr_valid;
  logic [$clog2(WRITE_SIZE+1)-1:0]       wr_count;
  logic                                  wr_ready;
  logic [READ_SIZE-1:0][DATA_WIDTH-1:0]  out;
  logic [READ_SIZE-1:0]                  out_valid;
  logic                                  rd_pop;
  logic [$clog2(READ_SIZE+1)-1:0]        rd_count;
  logic                                  rd_err;
  logic                                  flush;
  logic [$clog2(SIZE+1)-1:0]             occupancy;
  logic                                  full;
  logic                                  empty;

  modport master (
    output in, wr_valid, wr_count, rd_pop, rd_count, flush,
    input  wr_ready, out, out_valid, rd_err, occupancy, full, empty
  );

  modport slave (
    input  in, wr_valid, wr_count, rd_pop, rd_count, flush,
    output wr_ready, out, out_valid, rd_err, occupancy, full, empty
  );
endinterface

// File: rtl/multi_rate_circular_buffer.sv
// Circular buffer taking 0..WRITE_SIZE words per cycle and exposing a
// READ_SIZE-word head window that is popped 0..READ_SIZE words per cycle.
module multi_rate_circular_buffer #(
  parameter int SIZE       = 16,
  parameter int WRITE_SIZE = 4,
  parameter int READ_SIZE  = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic                         clk,
  input logic                         rst,
  multi_rate_circular_buffer_if.slave bus
);
  localparam int PW  = $clog2(SIZE);
  localparam int OW  = $clog2(SIZE + 1);
  localparam int WCW = $clog2(WRITE_SIZE + 1);
  localparam int RCW = $clog2(READ_SIZE + 1);

  localparam logic [WCW-1:0] WR_MAX  = WCW'(WRITE_SIZE);
  localparam logic [RCW-1:0] RD_MAX  = RCW'(READ_SIZE);
  localparam logic [OW-1:0]  OCC_MAX = OW'(SIZE);

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OW-1:0]         occ;
  logic                  rd_err_q;

  logic [OW-1:0] space;
  logic [OW-1:0] wr_amt;
  logic [OW-1:0] rd_amt;
  logic          wr_ok;
  logic          pop_ok;
  logic          wr_acc;
  logic          rd_acc;
  logic          rd_rej;
  logic [PW-1:0] wr_idx [WRITE_SIZE];

  logic [READ_SIZE-1:0][DATA_WIDTH-1:0] win;
  logic [READ_SIZE-1:0]                 win_valid;

  // Acceptance is judged purely on pre-edge occupancy, so a write and a pop
  // in the same cycle never see each other.
  // NOTE: every signal in this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    space  = OCC_MAX - occ;
    wr_ok  = (OW'(bus.wr_count) <= space) && (bus.wr_count <= WR_MAX);
    pop_ok = (OW'(bus.rd_count) <= occ) && (bus.rd_count <= RD_MAX);
    wr_acc = bus.wr_valid && wr_ok && !bus.flush && (bus.wr_count != '0);
    rd_acc = bus.rd_pop && pop_ok && !bus.flush && (bus.rd_count != '0);
    rd_rej = bus.rd_pop && !pop_ok;
    wr_amt = wr_acc ? OW'(bus.wr_count) : '0;
    rd_amt = rd_acc ? OW'(bus.rd_count) : '0;
    for (int k = 0; k < WRITE_SIZE; k++) begin
      wr_idx[k] = wr_ptr + PW'(k);
    end
  end

  // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      rd_err_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(bus.wr_count);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(bus.rd_count);
      occ      <= occ + wr_amt - rd_amt;
      rd_err_q <= rd_rej;
    end
  end

  // NOTE: the storage array is reset because the head window must read all-zero while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SIZE; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_acc) begin
      for (int k = 0; k < WRITE_SIZE; k++) begin
        if (WCW'(k) < bus.wr_count) mem[wr_idx[k]] <= bus.in[k];
      end
    end
  end

  // Head window wraps through natural pointer overflow; slots beyond occupancy show stale data.
  always_comb begin
    for (int j = 0; j < READ_SIZE; j++) begin
      win[j]       = mem[rd_ptr + PW'(j)];
      win_valid[j] = OW'(j) < occ;
    end
  end

  assign bus.out       = win;
  assign bus.out_valid = win_valid;
  assign bus.wr_ready  = wr_ok;
  assign bus.occupancy = occ;
  assign bus.full      = (occ == OCC_MAX);
  assign bus.empty     = (occ == '0);
  assign bus.rd_err    = rd_err_q;
endmodule

// File: tb/tb_multi_rate_circular_buffer.sv
// Directed bench: stimulus pushes time-stamped expectations into a scoreboard
// queue; a negedge monitor pops and compares them against the DUT outputs.
module tb_multi_rate_circular_buffer;
  logic clk;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  multi_rate_circular_buffer_if #(
    .SIZE(16), .WRITE_SIZE(4), .READ_SIZE(4), .DATA_WIDTH(8)
  ) bus ();

  multi_rate_circular_buffer #(
    .SIZE(16), .WRITE_SIZE(4), .READ_SIZE(4), .DATA_WIDTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum {S_OCC, S_EMPTY, S_FULL, S_WR_READY, S_RD_ERR, S_OUT, S_OUT_VALID} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_OCC:       return 32'(bus.occupancy);
      S_EMPTY:     return 32'(bus.empty);
      S_FULL:      return 32'(bus.full);
      S_WR_READY:  return 32'(bus.wr_ready);
      S_RD_ERR:    return 32'(bus.rd_err);
      S_OUT:       return 32'(bus.out);
      S_OUT_VALID: return 32'(bus.out_valid);
      default:     return '0;
    endcase
  endfunction

  // Monitor: compares every expectation stamped for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check(e.name, sample(e.sig), e.val);
    end
  end

  task automatic ex(input sig_e s, input logic [31:0] v, input string n);
    sb.push_back('{cyc, s, v, n});
  endtask

  function automatic logic [31:0] win(input logic [7:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0;
    bus.wr_count = '0;
    bus.in       = '0;
    bus.rd_pop   = 1'b0;
    bus.rd_count = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic wr(input int n, input logic [7:0] w0, w1, w2, w3);
    bus.wr_valid = 1'b1;
    bus.wr_count = 3'(n);
    bus.in       = {w3, w2, w1, w0};
  endtask

  task automatic pop(input int n);
    bus.rd_pop   = 1'b1;
    bus.rd_count = 3'(n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    step();
    step();
    ex(S_OCC, 0, "init_occ");
    ex(S_EMPTY, 1, "init_empty");
    ex(S_FULL, 0, "init_full");
    ex(S_WR_READY, 1, "init_wr_ready");
    ex(S_OUT_VALID, 0, "init_out_valid");
    step();

    // Basic write, then partial pop.
    rst = 1'b1;
    wr(4, 8'd10, 8'd11, 8'd12, 8'd13);
    ex(S_WR_READY, 1, "basic_wr_ready");
    step();
    idle();
    ex(S_OCC, 4, "basic_occ");
    ex(S_OUT, win(8'd10, 8'd11, 8'd12, 8'd13), "basic_out");
    ex(S_OUT_VALID, 4'b1111, "basic_out_valid");
    pop(3);
    step();
    idle();
    ex(S_OCC, 1, "pop3_occ");
    ex(S_OUT, win(8'd13, 8'd0, 8'd0, 8'd0), "pop3_out");
    ex(S_OUT_VALID, 4'b0001, "pop3_out_valid");

    // Reset asserted mid-burst after six more words.
    wr(4, 8'd1, 8'd2, 8'd3, 8'd4);
    step();
    wr(2, 8'd5, 8'd6, 8'd0, 8'd0);
    step();
    wr(4, 8'd7, 8'd8, 8'd9, 8'd10);
    rst = 1'b0;
    ex(S_OCC, 0, "rst_occ");
    ex(S_EMPTY, 1, "rst_empty");
    ex(S_FULL, 0, "rst_full");
    ex(S_WR_READY, 1, "rst_wr_ready");
    ex(S_OUT, 0, "rst_out");
    ex(S_OUT_VALID, 0, "rst_out_valid");
    step();
    rst = 1'b1;
    wr(1, 8'h77, 8'h00, 8'h00, 8'h00);
    ex(S_OCC, 0, "rst_hold_occ");
    step();
    idle();
    ex(S_OCC, 1, "post_rst_occ");
    ex(S_OUT, win(8'h77, 8'h00, 8'h00, 8'h00), "post_rst_out");

    // Fill to 14, then probe the full boundary.
    wr(4, 8'h30, 8'h31, 8'h32, 8'h33);
    step();
    wr(4, 8'h34, 8'h35, 8'h36, 8'h37);
    step();
    wr(4, 8'h38, 8'h39, 8'h3A, 8'h3B);
    step();
    wr(1, 8'h3C, 8'h00, 8'h00, 8'h00);
    step();
    wr(4, 8'h40, 8'h41, 8'h42, 8'h43);
    ex(S_OCC, 14, "fill_occ");
    ex(S_WR_READY, 0, "full_wr4_ready");
    step();
    wr(2, 8'hA0, 8'hA1, 8'h00, 8'h00);
    ex(S_OCC, 14, "full_rejected_occ");
    ex(S_WR_READY, 1, "full_wr2_ready");
    step();
    wr(1, 8'hEE, 8'h00, 8'h00, 8'h00);
    ex(S_FULL, 1, "full_flag");
    ex(S_OCC, 16, "full_occ");
    ex(S_WR_READY, 0, "full_wr1_ready");
    ex(S_OUT, win(8'h77, 8'h30, 8'h31, 8'h32), "full_out");
    step();
    idle();
    ex(S_OCC, 16, "full_hold_occ");

    // Drain to 9 and flush with a concurrent write and pop.
    pop(4);
    step();
    idle();
    ex(S_OCC, 12, "drain4_occ");
    ex(S_OUT, win(8'h33, 8'h34, 8'h35, 8'h36), "drain4_out");
    pop(3);
    step();
    idle();
    ex(S_OCC, 9, "drain3_occ");
    wr(4, 8'h55, 8'h56, 8'h57, 8'h58);
    pop(2);
    bus.flush = 1'b1;
    step();
    idle();
    ex(S_OCC, 0, "flush_occ");
    ex(S_EMPTY, 1, "flush_empty");
    ex(S_OUT_VALID, 0, "flush_out_valid");
    ex(S_OUT, win(8'h77, 8'h30, 8'h31, 8'h32), "flush_mem_kept");
    wr(1, 8'h99, 8'h00, 8'h00, 8'h00);
    step();
    idle();
    ex(S_OCC, 1, "post_flush_occ");
    ex(S_OUT, win(8'h99, 8'h30, 8'h31, 8'h32), "post_flush_out");
    ex(S_OUT_VALID, 4'b0001, "post_flush_out_valid");

    // Underflow at occupancy 2, then a zero-count pop.
    wr(1, 8'h9A, 8'h00, 8'h00, 8'h00);
    step();
    idle();
    pop(3);
    step();
    idle();
    ex(S_RD_ERR, 1, "underflow_rd_err");
    ex(S_OCC, 2, "underflow_occ");
    ex(S_OUT, win(8'h99, 8'h9A, 8'h31, 8'h32), "underflow_out");
    pop(0);
    step();
    idle();
    ex(S_RD_ERR, 0, "underflow_pulse_end");
    ex(S_OCC, 2, "pop0_occ");

    // Simultaneous write 3 / pop 2 at occupancy 5.
    wr(3, 8'hA2, 8'hA3, 8'hA4, 8'h00);
    step();
    wr(3, 8'hB5, 8'hB6, 8'hB7, 8'h00);
    pop(2);
    ex(S_OCC, 5, "simul_pre_occ");
    step();
    idle();
    ex(S_OCC, 6, "simul_occ");
    ex(S_OUT, win(8'hA2, 8'hA3, 8'hA4, 8'hB5), "simul_out");
    ex(S_OUT_VALID, 4'b1111, "simul_out_valid");

    // Move both pointers to 14 with the buffer empty, then write across the wrap.
    wr(4, 8'hC8, 8'hC9, 8'hCA, 8'hCB);
    pop(4);
    step();
    wr(2, 8'hCC, 8'hCD, 8'h00, 8'h00);
    pop(4);
    step();
    idle();
    pop(4);
    step();
    idle();
    ex(S_EMPTY, 1, "prewrap_empty");
    wr(4, 8'd20, 8'd21, 8'd22, 8'd23);
    step();
    idle();
    ex(S_OCC, 4, "wrap_occ");
    ex(S_OUT, win(8'd20, 8'd21, 8'd22, 8'd23), "wrap_out");
    ex(S_OUT_VALID, 4'b1111, "wrap_out_valid");
    pop(2);
    step();
    idle();
    ex(S_OUT, win(8'd22, 8'd23, 8'hA2, 8'hA3), "wrap_pop_out");
    ex(S_OUT_VALID, 4'b0011, "wrap_pop_out_valid");

    // Pop checked against pre-edge occupancy while a write lands.
    wr(4, 8'hD0, 8'hD1, 8'hD2, 8'hD3);
    pop(3);
    step();
    idle();
    wr(5, 8'hE0, 8'hE1, 8'hE2, 8'hE3);
    ex(S_RD_ERR, 1, "preedge_rd_err");
    ex(S_OCC, 6, "preedge_occ");
    ex(S_OUT, win(8'd22, 8'd23, 8'hD0, 8'hD1), "preedge_out");
    ex(S_WR_READY, 0, "illegal_wr_count_ready");
    step();
    idle();
    pop(5);
    ex(S_OCC, 6, "illegal_wr_occ");
    ex(S_RD_ERR, 0, "illegal_wr_rd_err");
    ex(S_OUT, win(8'd22, 8'd23, 8'hD0, 8'hD1), "illegal_wr_out");
    step();
    idle();
    ex(S_RD_ERR, 1, "over_read_size_rd_err");
    ex(S_OCC, 6, "over_read_size_occ");
    step();
    ex(S_RD_ERR, 0, "over_read_size_pulse_end");

    step();
    step();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
